// File: rtl/alu_writeback_pkg.sv
// Shared constants for the ALU writeback stage: static-bundle field offsets,
// link-address increment and writeback queue depth.
package alu_writeback_pkg;

  // Offsets of the control fields above the instruction address in the static bundle
  localparam int ST_WE_OFS   = 0;
  localparam int ST_LINK_OFS = 1;
  localparam int ST_DEST_OFS = 2;

  localparam int LINK_INC = 4;
  localparam int WB_DEPTH = 2;
  localparam int WB_CNT_W = $clog2(WB_DEPTH + 1);

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-to-writeback handshake, register-file write port, bypass lookup and retire count.
// The master drives the ALU-side/RF-side inputs; the slave is the writeback stage.
interface alu_writeback_if #(
  parameter int OPERAND_SIZE     = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int ADDRESS_SIZE     = 32
);
  localparam int SW = REG_ADDRESS_SIZE + 2 + ADDRESS_SIZE;

  logic                        in_valid;
  logic                        in_ready;
  logic [OPERAND_SIZE-1:0]     in_result;
  logic [SW-1:0]               in_static;
  logic                        rf_we;
  logic [REG_ADDRESS_SIZE-1:0] rf_waddr;
  logic [OPERAND_SIZE-1:0]     rf_wdata;
  logic                        rf_ready;
  logic [REG_ADDRESS_SIZE-1:0] fwd_query;
  logic                        fwd_hit;
  logic [OPERAND_SIZE-1:0]     fwd_data;
  logic [15:0]                 retired;

  modport master (
    output in_valid, in_result, in_static, rf_ready, fwd_query,
    input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, retired
  );

  modport slave (
    input  in_valid, in_result, in_static, rf_ready, fwd_query,
    output in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, retired
  );
endinterface

// File: rtl/alu_writeback_queue.sv
// wb_queue: 2-entry in-order queue, head at slot 0; entries visible one cycle after enqueue.
// Full flag comes from registered occupancy only; youngest matching writer wins the bypass lookup.
module wb_queue
  import alu_writeback_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_enq,
  input  logic          i_wr,
  input  logic [AW-1:0] i_dest,
  input  logic [DW-1:0] i_data,
  input  logic          i_deq,
  input  logic [AW-1:0] i_fwd_query,
  output logic          o_full,
  output logic          o_head_vld,
  output logic          o_head_wr,
  output logic [AW-1:0] o_head_dest,
  output logic [DW-1:0] o_head_data,
  output logic          o_fwd_hit,
  output logic [DW-1:0] o_fwd_data
);

  logic [WB_CNT_W-1:0] r_count;
  logic [WB_DEPTH-1:0] r_vld;
  logic [WB_DEPTH-1:0] r_wr;
  logic [AW-1:0]       r_dest [WB_DEPTH];
  logic [DW-1:0]       r_data [WB_DEPTH];
  logic                w_slot;

  // Enqueue is never offered when full, so the write slot is count or count-1.
  assign w_slot = i_deq ? 1'b0 : r_count[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_vld   <= '0;
      r_wr    <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        r_dest[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (i_deq) begin
        r_vld[0]  <= r_vld[1];
        r_wr[0]   <= r_wr[1];
        r_dest[0] <= r_dest[1];
        r_data[0] <= r_data[1];
        r_vld[1]  <= 1'b0;
      end
      if (i_enq) begin
        r_vld[w_slot]  <= 1'b1;
        r_wr[w_slot]   <= i_wr;
        r_dest[w_slot] <= i_dest;
        r_data[w_slot] <= i_data;
      end
      r_count <= r_count + WB_CNT_W'(i_enq) - WB_CNT_W'(i_deq);
    end
  end

  assign o_full      = (r_count == WB_CNT_W'(WB_DEPTH));
  assign o_head_vld  = r_vld[0];
  assign o_head_wr   = r_wr[0];
  assign o_head_dest = r_dest[0];
  assign o_head_data = r_data[0];

  always_comb begin
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    if (i_fwd_query != '0) begin
      // Ascending scan so the younger slot overrides the older one.
      for (int i = 0; i < WB_DEPTH; i++) begin
        if (r_vld[i] && r_wr[i] && (r_dest[i] == i_fwd_query)) begin
          o_fwd_hit  = 1'b1;
          o_fwd_data = r_data[i];
        end
      end
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: link mux and write qualification into a 2-entry queue, RF write from head.
// 1-cycle latency to the RF port; in_ready drops at 2 queued entries; non-writing entries retire without rf_ready.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int OPERAND_SIZE     = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int ADDRESS_SIZE     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_writeback_if.slave   wb
);

  logic [ADDRESS_SIZE-1:0]     w_addr;
  logic [ADDRESS_SIZE-1:0]     w_link_addr;
  logic                        w_we;
  logic                        w_link;
  logic [REG_ADDRESS_SIZE-1:0] w_dest;
  logic [OPERAND_SIZE-1:0]     w_enq_data;
  logic                        w_enq_wr;
  logic                        w_enq;
  logic                        w_deq;
  logic                        w_full;
  logic                        w_head_vld;
  logic                        w_head_wr;
  logic [REG_ADDRESS_SIZE-1:0] w_head_dest;
  logic [OPERAND_SIZE-1:0]     w_head_data;
  logic [15:0]                 r_retired;

  assign w_addr      = wb.in_static[ADDRESS_SIZE-1:0];
  assign w_we        = wb.in_static[ADDRESS_SIZE + ST_WE_OFS];
  assign w_link      = wb.in_static[ADDRESS_SIZE + ST_LINK_OFS];
  assign w_dest      = wb.in_static[ADDRESS_SIZE + ST_DEST_OFS +: REG_ADDRESS_SIZE];
  assign w_link_addr = w_addr + ADDRESS_SIZE'(LINK_INC);
  assign w_enq_data  = w_link ? OPERAND_SIZE'(w_link_addr) : wb.in_result;
  // Register 0 is hardwired, so a write to it is treated as a plain retire.
  assign w_enq_wr    = w_we && (w_dest != '0);

  assign wb.in_ready = !w_full;
  assign w_enq       = wb.in_valid && !w_full;
  assign w_deq       = w_head_vld && (!w_head_wr || wb.rf_ready);

  wb_queue #(
    .DW (OPERAND_SIZE),
    .AW (REG_ADDRESS_SIZE)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_enq       (w_enq),
    .i_wr        (w_enq_wr),
    .i_dest      (w_dest),
    .i_data      (w_enq_data),
    .i_deq       (w_deq),
    .i_fwd_query (wb.fwd_query),
    .o_full      (w_full),
    .o_head_vld  (w_head_vld),
    .o_head_wr   (w_head_wr),
    .o_head_dest (w_head_dest),
    .o_head_data (w_head_data),
    .o_fwd_hit   (wb.fwd_hit),
    .o_fwd_data  (wb.fwd_data)
  );

  assign wb.rf_we    = w_head_vld && w_head_wr;
  assign wb.rf_waddr = wb.rf_we ? w_head_dest : '0;
  assign wb.rf_wdata = wb.rf_we ? w_head_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_deq) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign wb.retired = r_retired;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with a scoreboard of expected register-file writes.
module tb_alu_writeback;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [36:0] sb[$];

  alu_writeback_if #(.OPERAND_SIZE(32), .REG_ADDRESS_SIZE(5), .ADDRESS_SIZE(32)) u_if ();

  alu_writeback #(.OPERAND_SIZE(32), .REG_ADDRESS_SIZE(5), .ADDRESS_SIZE(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] res, input logic [31:0] addr, input logic we,
                     input logic link, input logic [4:0] dest);
    logic [31:0] d;
    u_if.in_result = res;
    u_if.in_static = {dest, link, we, addr};
    u_if.in_valid  = 1'b1;
    check("enq_ready", {31'd0, u_if.in_ready}, 32'd1);
    d = link ? addr + 32'd4 : res;
    if (we && dest != 5'd0) sb.push_back({dest, d});
    tick();
    u_if.in_valid = 1'b0;
  endtask

  // Scoreboard: every accepted RF write must match the oldest expected write.
  always @(negedge clk) begin
    if (u_if.rf_we === 1'b1 && u_if.rf_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {27'd0, u_if.rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        check("sb_waddr", {27'd0, u_if.rf_waddr}, {27'd0, e[36:32]});
        check("sb_wdata", u_if.rf_wdata, e[31:0]);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_result = '0;
    u_if.in_static = '0;
    u_if.rf_ready  = 1'b0;
    u_if.fwd_query = '0;
    #1;
    check("rst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
    check("rst_rf_we",    {31'd0, u_if.rf_we}, 32'd0);
    check("rst_waddr",    {27'd0, u_if.rf_waddr}, 32'd0);
    check("rst_wdata",    u_if.rf_wdata, 32'd0);
    check("rst_fwd_hit",  {31'd0, u_if.fwd_hit}, 32'd0);
    check("rst_fwd_data", u_if.fwd_data, 32'd0);
    check("rst_retired",  {16'd0, u_if.retired}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic write
    u_if.rf_ready = 1'b1;
    enq(32'h0000_00AA, 32'h0, 1'b1, 1'b0, 5'd3);
    check("basic_we",    {31'd0, u_if.rf_we}, 32'd1);
    check("basic_waddr", {27'd0, u_if.rf_waddr}, 32'd3);
    check("basic_wdata", u_if.rf_wdata, 32'h0000_00AA);
    tick();
    check("basic_retired", {16'd0, u_if.retired}, 32'd1);
    check("basic_idle_we", {31'd0, u_if.rf_we}, 32'd0);

    // Link select
    enq(32'h0000_DEAD, 32'h0000_1000, 1'b1, 1'b1, 5'd31);
    check("link_waddr", {27'd0, u_if.rf_waddr}, 32'd31);
    check("link_wdata", u_if.rf_wdata, 32'h0000_1004);
    tick();
    check("link_retired", {16'd0, u_if.retired}, 32'd2);

    // Backpressure
    u_if.rf_ready = 1'b0;
    enq(32'h111, 32'h0, 1'b1, 1'b0, 5'd7);
    enq(32'h222, 32'h0, 1'b1, 1'b0, 5'd8);
    check("bp_full_ready", {31'd0, u_if.in_ready}, 32'd0);
    u_if.in_result = 32'h333;
    u_if.in_static = {5'd9, 1'b0, 1'b1, 32'h0};
    u_if.in_valid  = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
    check("bp_hold_ready", {31'd0, u_if.in_ready}, 32'd0);
    check("bp_hold_waddr", {27'd0, u_if.rf_waddr}, 32'd7);
    u_if.rf_ready = 1'b1;
    tick();
    check("bp_ready_after_deq", {31'd0, u_if.in_ready}, 32'd1);
    check("bp_second_waddr", {27'd0, u_if.rf_waddr}, 32'd8);
    check("bp_retired1", {16'd0, u_if.retired}, 32'd3);
    tick();
    check("bp_retired2", {16'd0, u_if.retired}, 32'd4);
    check("bp_drained_we", {31'd0, u_if.rf_we}, 32'd0);

    // Forwarding
    u_if.rf_ready = 1'b0;
    enq(32'h11, 32'h0, 1'b1, 1'b0, 5'd5);
    u_if.fwd_query = 5'd5;
    #1;
    check("fwd_old_hit",  {31'd0, u_if.fwd_hit}, 32'd1);
    check("fwd_old_data", u_if.fwd_data, 32'h11);
    enq(32'h22, 32'h0, 1'b1, 1'b0, 5'd5);
    check("fwd_young_hit",  {31'd0, u_if.fwd_hit}, 32'd1);
    check("fwd_young_data", u_if.fwd_data, 32'h22);
    u_if.fwd_query = 5'd3;
    #1;
    check("fwd_miss_hit",  {31'd0, u_if.fwd_hit}, 32'd0);
    check("fwd_miss_data", u_if.fwd_data, 32'd0);
    u_if.fwd_query = 5'd0;
    #1;
    check("fwd_zero_hit", {31'd0, u_if.fwd_hit}, 32'd0);
    u_if.rf_ready = 1'b1;
    tick();
    tick();
    check("fwd_retired", {16'd0, u_if.retired}, 32'd6);

    // Discarded (dest 0) and non-writing entries retire without rf_ready
    u_if.rf_ready = 1'b0;
    enq(32'h55, 32'h0, 1'b1, 1'b0, 5'd0);
    check("disc_we",    {31'd0, u_if.rf_we}, 32'd0);
    check("disc_waddr", {27'd0, u_if.rf_waddr}, 32'd0);
    check("disc_wdata", u_if.rf_wdata, 32'd0);
    enq(32'h66, 32'h0, 1'b0, 1'b0, 5'd4);
    u_if.fwd_query = 5'd4;
    #1;
    check("nowr_fwd_hit", {31'd0, u_if.fwd_hit}, 32'd0);
    check("nowr_retired", {16'd0, u_if.retired}, 32'd7);
    u_if.fwd_query = 5'd0;
    tick();
    check("disc_retired", {16'd0, u_if.retired}, 32'd8);
    check("disc_ready",   {31'd0, u_if.in_ready}, 32'd1);

    // Reset mid-stream with two queued writes
    enq(32'hA0, 32'h0, 1'b1, 1'b0, 5'd10);
    enq(32'hB0, 32'h0, 1'b1, 1'b0, 5'd11);
    check("mid_full", {31'd0, u_if.in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    u_if.fwd_query = 5'd10;
    #1;
    check("mid_rst_we",      {31'd0, u_if.rf_we}, 32'd0);
    check("mid_rst_ready",   {31'd0, u_if.in_ready}, 32'd1);
    check("mid_rst_retired", {16'd0, u_if.retired}, 32'd0);
    check("mid_rst_fwd_hit", {31'd0, u_if.fwd_hit}, 32'd0);
    sb.delete();
    u_if.fwd_query = 5'd0;
    u_if.rf_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    enq(32'h77, 32'h0, 1'b1, 1'b0, 5'd12);
    check("post_rst_waddr", {27'd0, u_if.rf_waddr}, 32'd12);
    tick();
    check("post_rst_retired", {16'd0, u_if.retired}, 32'd1);
    check("post_rst_we",      {31'd0, u_if.rf_we}, 32'd0);

    // Retire counter wrap: back-to-back non-writing entries at one per cycle
    u_if.in_result = 32'h0;
    u_if.in_static = {5'd0, 1'b0, 1'b0, 32'h0};
    u_if.in_valid  = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    u_if.in_valid = 1'b0;
    tick();
    check("wrap_ffff", {16'd0, u_if.retired}, 32'h0000_FFFF);
    enq(32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    tick();
    check("wrap_zero",  {16'd0, u_if.retired}, 32'h0000_0000);
    check("end_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
